// File: rtl/rv32i_trace_buffer.sv
// rv32i_trace_buffer: circular commit-trace recorder with halt detection and oldest-first readout.
// Optional macro TRACE_TIMESTAMP_EN adds a 32-bit cycle timestamp to every entry.
module rv32i_trace_buffer #(
  parameter int DEPTH        = 64,
  parameter int HALT_MODE    = 3,
  parameter int STOP_ON_FULL = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_arm,
  input  logic                     i_trigger,
  input  logic                     i_evt_valid,
  input  logic [2:0]               i_evt_type,
  input  logic [31:0]              i_evt_pc,
  input  logic [31:0]              i_evt_addr,
  input  logic [31:0]              i_evt_data,
  input  logic                     i_rd_en,
  output logic                     o_rd_valid,
  output logic [2:0]               o_rd_type,
  output logic [31:0]              o_rd_pc,
  output logic [31:0]              o_rd_addr,
  output logic [31:0]              o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_halt,
  output logic [1:0]               o_state
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]              o_rd_timestamp
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam bit HALT_EB = (HALT_MODE & 1) != 0;
  localparam bit HALT_EC = (HALT_MODE & 2) != 0;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_HALTED = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            rd_valid_q, rd_valid_d;
  logic [2:0]      rd_type_q, rd_type_d;
  logic [31:0]     rd_pc_q, rd_pc_d, rd_addr_q, rd_addr_d, rd_data_q, rd_data_d;
  logic            wr_en, evt_ok, full, halt_hit;

  logic [2:0]      mem_type [DEPTH];
  logic [31:0]     mem_pc   [DEPTH];
  logic [31:0]     mem_addr [DEPTH];
  logic [31:0]     mem_data [DEPTH];

  assign evt_ok   = i_evt_valid && (i_evt_type <= 3'd5);
  assign full     = count_q == FULL_CNT;
  assign halt_hit = i_trigger || (i_evt_valid && i_evt_type == 3'd0 &&
                    ((HALT_EB && i_evt_addr == 32'h0010_0073) ||
                     (HALT_EC && i_evt_addr == 32'h0000_0073)));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rd_valid_d = 1'b0;
    rd_type_d  = rd_type_q;
    rd_pc_d    = rd_pc_q;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    wr_en      = 1'b0;
    if (i_arm) begin
      state_d    = S_ARMED;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (state_q == S_ARMED) begin
      if (evt_ok && !full) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end else if (evt_ok) begin
        overflow_d = 1'b1;
        // Wrap mode overwrites the oldest entry, so the read side slides forward too
        if (STOP_ON_FULL == 0) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      if (halt_hit) state_d = S_HALTED;
    end else if (state_q == S_HALTED && i_rd_en && count_q != '0) begin
      rd_valid_d = 1'b1;
      rd_type_d  = mem_type[rd_ptr_q];
      rd_pc_d    = mem_pc[rd_ptr_q];
      rd_addr_d  = mem_addr[rd_ptr_q];
      rd_data_d  = mem_data[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + 1'b1;
      count_d    = count_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_type_q  <= '0;
      rd_pc_q    <= '0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      rd_type_q  <= rd_type_d;
      rd_pc_q    <= rd_pc_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage is deliberately left unreset so it maps onto plain RAM
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_type[wr_ptr_q] <= i_evt_type;
      mem_pc[wr_ptr_q]   <= i_evt_pc;
      mem_addr[wr_ptr_q] <= i_evt_addr;
      mem_data[wr_ptr_q] <= i_evt_data;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d, rd_ts_q, rd_ts_d;
  logic [31:0] mem_ts [DEPTH];

  always_comb begin
    ts_d    = ts_q + 32'd1;
    rd_ts_d = rd_valid_d ? mem_ts[rd_ptr_q] : rd_ts_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ts_q    <= '0;
      rd_ts_q <= '0;
    end else begin
      ts_q    <= ts_d;
      rd_ts_q <= rd_ts_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_ts[wr_ptr_q] <= ts_q;
  end

  assign o_rd_timestamp = rd_ts_q;
`endif

  assign o_rd_valid = rd_valid_q;
  assign o_rd_type  = rd_type_q;
  assign o_rd_pc    = rd_pc_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_rd_data  = rd_data_q;
  assign o_count    = count_q;
  assign o_overflow = overflow_q;
  assign o_halt     = state_q == S_HALTED;
  assign o_state    = state_q;
endmodule

// File: tb/tb_rv32i_trace_buffer.sv
// tb_rv32i_trace_buffer: directed checks of three trace buffer configurations sharing one event bus.
module tb_rv32i_trace_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  arm = '0, trig = '0, rd = '0;
  logic        ev = 1'b0;
  logic [2:0]  ev_type = '0;
  logic [31:0] ev_pc = '0, ev_addr = '0, ev_data = '0;
  int          checks = 0, errors = 0;

  logic        va, vb, vc, ova, ovb, ovc, ha, hb, hc;
  logic [2:0]  ta, tb, tc;
  logic [31:0] pa, pb, pc_c, aa, ab, ac, da, db, dc;
  logic [6:0]  cnt_a;
  logic [2:0]  cnt_b, cnt_c;
  logic [1:0]  sa, sb, sc;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_a, ts_b, ts_c, t1;
`endif

  always #5 clk = ~clk;

  rv32i_trace_buffer #(.DEPTH(64), .HALT_MODE(3), .STOP_ON_FULL(0)) u_a (
    .i_clk(clk), .i_rst(rst), .i_arm(arm[0]), .i_trigger(trig[0]), .i_evt_valid(ev),
    .i_evt_type(ev_type), .i_evt_pc(ev_pc), .i_evt_addr(ev_addr), .i_evt_data(ev_data),
    .i_rd_en(rd[0]), .o_rd_valid(va), .o_rd_type(ta), .o_rd_pc(pa), .o_rd_addr(aa),
    .o_rd_data(da), .o_count(cnt_a), .o_overflow(ova), .o_halt(ha), .o_state(sa)
`ifdef TRACE_TIMESTAMP_EN
    , .o_rd_timestamp(ts_a)
`endif
  );

  rv32i_trace_buffer #(.DEPTH(4), .HALT_MODE(1), .STOP_ON_FULL(0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_arm(arm[1]), .i_trigger(trig[1]), .i_evt_valid(ev),
    .i_evt_type(ev_type), .i_evt_pc(ev_pc), .i_evt_addr(ev_addr), .i_evt_data(ev_data),
    .i_rd_en(rd[1]), .o_rd_valid(vb), .o_rd_type(tb), .o_rd_pc(pb), .o_rd_addr(ab),
    .o_rd_data(db), .o_count(cnt_b), .o_overflow(ovb), .o_halt(hb), .o_state(sb)
`ifdef TRACE_TIMESTAMP_EN
    , .o_rd_timestamp(ts_b)
`endif
  );

  rv32i_trace_buffer #(.DEPTH(4), .HALT_MODE(2), .STOP_ON_FULL(1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_arm(arm[2]), .i_trigger(trig[2]), .i_evt_valid(ev),
    .i_evt_type(ev_type), .i_evt_pc(ev_pc), .i_evt_addr(ev_addr), .i_evt_data(ev_data),
    .i_rd_en(rd[2]), .o_rd_valid(vc), .o_rd_type(tc), .o_rd_pc(pc_c), .o_rd_addr(ac),
    .o_rd_data(dc), .o_count(cnt_c), .o_overflow(ovc), .o_halt(hc), .o_state(sc)
`ifdef TRACE_TIMESTAMP_EN
    , .o_rd_timestamp(ts_c)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] t, input logic [31:0] p, input logic [31:0] a,
                      input logic [31:0] d);
    ev = 1'b1; ev_type = t; ev_pc = p; ev_addr = a; ev_data = d;
    tick();
    ev = 1'b0;
  endtask

  task automatic pulse_arm(input logic [2:0] m);
    arm = m;
    tick();
    arm = '0;
  endtask

  task automatic pulse_trig(input logic [2:0] m);
    trig = m;
    tick();
    trig = '0;
  endtask

  task automatic pop(input logic [2:0] m);
    rd = m;
    tick();
    rd = '0;
  endtask

  initial begin
    #2;
    chk("rst_state", 32'(sa), 32'd0);
    chk("rst_count", 32'(cnt_a), 32'd0);
    chk("rst_halt", 32'(ha), 32'd0);
    chk("rst_rd_valid", 32'(va), 32'd0);
    #10 rst = 1'b0;
    tick();
    send(3'd0, 32'h40, 32'h13, 32'h0);
    chk("idle_ignores_evt", 32'(cnt_a), 32'd0);

    // Test 1: five retires then ebreak, readout oldest first
    pulse_arm(3'b001);
    chk("t1_armed", 32'(sa), 32'd1);
    rd = 3'b001;
    tick();
    rd = '0;
    chk("t1_rd_in_armed", 32'(va), 32'd0);
    for (int i = 0; i < 5; i++) send(3'd0, 32'(4 * i), 32'h0000_0013, 32'h0);
    chk("t1_still_armed", 32'(sa), 32'd1);
    send(3'd0, 32'h14, 32'h0010_0073, 32'h0);
    chk("t1_state", 32'(sa), 32'd2);
    chk("t1_halt", 32'(ha), 32'd1);
    chk("t1_count", 32'(cnt_a), 32'd6);
    send(3'd0, 32'h80, 32'h13, 32'h0);
    chk("t1_frozen", 32'(cnt_a), 32'd6);
    for (int i = 0; i < 6; i++) begin
      pop(3'b001);
      chk("t1_pop_valid", 32'(va), 32'd1);
      chk("t1_pop_pc", pa, 32'(4 * i));
      tick();
      chk("t1_valid_pulse", 32'(va), 32'd0);
    end
    chk("t1_empty", 32'(cnt_a), 32'd0);
    pop(3'b001);
    chk("t1_empty_pop_valid", 32'(va), 32'd0);
    chk("t1_empty_pop_hold", pa, 32'h14);

    // Arm coincident with a halt condition re-arms instead of halting
    pulse_arm(3'b001);
    arm = 3'b001; ev = 1'b1; ev_type = 3'd0; ev_pc = 32'h0; ev_addr = 32'h0010_0073;
    tick();
    arm = '0; ev = 1'b0;
    chk("arm_prio_state", 32'(sa), 32'd1);
    chk("arm_prio_halt", 32'(ha), 32'd0);
    chk("arm_prio_count", 32'(cnt_a), 32'd0);

    // Tests 2 and 3: DEPTH=4 wrap (u_b) versus stop-on-full (u_c)
    pulse_arm(3'b110);
    for (int i = 0; i < 6; i++) send(3'd1, 32'h100 + 32'(i), 32'(i), 32'(i + 1));
    pulse_trig(3'b110);
    chk("t2_state", 32'(sb), 32'd2);
    chk("t2_overflow", 32'(ovb), 32'd1);
    chk("t2_count", 32'(cnt_b), 32'd4);
    chk("t3_state", 32'(sc), 32'd2);
    chk("t3_overflow", 32'(ovc), 32'd1);
    chk("t3_count", 32'(cnt_c), 32'd4);
    for (int i = 0; i < 4; i++) begin
      pop(3'b110);
      chk("t2_pop_valid", 32'(vb), 32'd1);
      chk("t2_pop_data", db, 32'(i + 3));
      chk("t3_pop_valid", 32'(vc), 32'd1);
      chk("t3_pop_data", dc, 32'(i + 1));
    end
    chk("t2_pop_type", 32'(tb), 32'd1);
    chk("t3_pop_addr", ac, 32'd3);

    // Test 4: ecall only halts the HALT_MODE=2 instance
    pulse_arm(3'b110);
    chk("t4_ovf_cleared", 32'(ovb), 32'd0);
    send(3'd0, 32'h300, 32'h0000_0073, 32'h0);
    chk("t4_m1_state", 32'(sb), 32'd1);
    chk("t4_m1_halt", 32'(hb), 32'd0);
    chk("t4_m2_state", 32'(sc), 32'd2);
    chk("t4_m2_halt", 32'(hc), 32'd1);
    send(3'd0, 32'h304, 32'h0010_0073, 32'h0);
    chk("t4_m1_ebreak", 32'(sb), 32'd2);
    chk("t4_m1_count", 32'(cnt_b), 32'd2);

    // Test 5: asynchronous reset mid-readout
    pulse_arm(3'b001);
    for (int i = 0; i < 6; i++) send(3'd0, 32'h200 + 32'(4 * i), 32'h13, 32'h0);
    pulse_trig(3'b001);
    pop(3'b001);
    pop(3'b001);
    chk("t5_second_pop", pa, 32'h204);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_state", 32'(sa), 32'd0);
    chk("t5_rst_halt", 32'(ha), 32'd0);
    chk("t5_rst_count", 32'(cnt_a), 32'd0);
    chk("t5_rst_valid", 32'(va), 32'd0);
    chk("t5_rst_pc", pa, 32'd0);
    chk("t5_rst_ovf_b", 32'(ovb), 32'd0);
    #1 rst = 1'b0;
    tick();
    pulse_arm(3'b001);
    send(3'd2, 32'h400, 32'h8000_0000, 32'hdead_beef);
    chk("t5_rearm_count", 32'(cnt_a), 32'd1);

`ifdef TRACE_TIMESTAMP_EN
    // Test 6: timestamps of events three cycles apart
    pulse_arm(3'b001);
    tick();
    send(3'd0, 32'h500, 32'h13, 32'h0);
    tick();
    tick();
    send(3'd0, 32'h504, 32'h13, 32'h0);
    pulse_trig(3'b001);
    pop(3'b001);
    t1 = ts_a;
    pop(3'b001);
    chk("t6_ts_delta", ts_a - t1, 32'd3);
    chk("t6_pc", pa, 32'h504);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32i_trace_buffer.md
Name: rv32i_trace_buffer

Overview:
Parametrised on-chip commit-trace recorder for the rv32i core, for simulation and FPGA debug. It captures retire, base-register, memory-write, CSR and trap events into a circular buffer. It detects a configurable halt instruction (ebreak/ecall) or an external trigger, freezes capture, asserts a halt request to the SoC, and allows the captured history to be read out oldest-first.

Parameters:
- DEPTH, 64, number of trace entries; power of two, min 4.
- HALT_MODE, 3, halt source select: 0 = none, 1 = ebreak (32'h00100073), 2 = ecall (32'h00000073), 3 = either.
- STOP_ON_FULL, 0, full-buffer policy: 0 = overwrite oldest entry (wrap), 1 = stop capturing when full.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_arm  in  1  pulse; clears pointers and starts capture
- i_trigger  in  1  external halt trigger, level-sampled
- i_evt_valid  in  1  event present this cycle
- i_evt_type  in  3  0 RETIRE, 1 BASEREG, 2 MEM, 3 CSR, 4 TRAP, 5 MRET; 6-7 ignored
- i_evt_pc  in  32  PC of the originating instruction
- i_evt_addr  in  32  RETIRE: instruction word; BASEREG: rd index; MEM: byte address; CSR: csr index; TRAP: {intbit, 27'b0, code[3:0]}
- i_evt_data  in  32  value written (0 for RETIRE/TRAP/MRET)
- i_rd_en  in  1  pop the oldest entry; honoured only in HALTED
- o_rd_valid  out  1  read data valid
- o_rd_type  out  3  entry type
- o_rd_pc  out  32  entry PC
- o_rd_addr  out  32  entry address field
- o_rd_data  out  32  entry data field
- o_count  out  $clog2(DEPTH)+1  entries currently held
- o_overflow  out  1  sticky; at least one entry was overwritten or dropped
- o_halt  out  1  halt request to the core; high in HALTED
- o_state  out  2  0 IDLE, 1 ARMED, 2 HALTED

Behaviour:
- Reset: state IDLE, all pointers and o_count 0, o_rd_valid 0, o_rd_* 0, o_overflow 0, o_halt 0. Storage contents are not cleared. Reset asserted mid-capture or mid-readout aborts immediately.
- IDLE:
  - i_arm -> ARMED next cycle; wr_ptr, rd_ptr, o_count and o_overflow are cleared.
  - Events are ignored.
- ARMED: each cycle with i_evt_valid and a type in 0-5 writes one entry at wr_ptr, then wr_ptr advances mod DEPTH.
  - Full with STOP_ON_FULL=0: the write overwrites the oldest entry, rd_ptr advances, o_count stays DEPTH, o_overflow is set.
  - Full with STOP_ON_FULL=1: the write is dropped and o_overflow is set.
- Halt detection in ARMED: a RETIRE event whose i_evt_addr matches a HALT_MODE instruction, or i_trigger high, sends the state to HALTED next cycle.
  - The matching RETIRE entry is itself captured as the newest entry.
  - o_halt rises in the same cycle the state becomes HALTED.
  - i_arm in the same cycle as the halt condition takes priority: re-arm, no halt.
- HALTED: capture stops; o_halt stays high.
  - i_rd_en with o_count>0: the entry at rd_ptr is presented on o_rd_* with o_rd_valid=1 one cycle later. rd_ptr then advances and o_count decrements.
  - i_rd_en with o_count==0: o_rd_valid=0 and o_rd_* hold their previous values.
  - i_arm -> ARMED, clears pointers, o_halt drops next cycle. An i_rd_en in the same cycle as i_arm is ignored.
- i_rd_en outside HALTED: no effect.
- o_rd_valid is a one-cycle pulse per accepted pop.
- Wrap-around: pointers are $clog2(DEPTH) bits and roll over naturally. o_count saturates at DEPTH.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter (reset 0, wraps at 2^32) is stored with every entry.
  - Extra port o_rd_timestamp (out, 32) is valid alongside o_rd_valid.
  - i_arm does not reset the counter.
- Undefined: no counter, no timestamp storage, no o_rd_timestamp port.

Test Plan:
1. Reset, arm, 5 RETIRE events (pc 0x0,0x4,...,0x10), then RETIRE with addr=0x00100073 at pc 0x14 -> o_state=2, o_halt=1 the next cycle; o_count=6; six pops return pc 0x0..0x14 in order, each with o_rd_valid one cycle after i_rd_en.
2. DEPTH=4, STOP_ON_FULL=0, arm, 6 BASEREG events with data 1..6, then i_trigger -> o_overflow=1, o_count=4, pops return data 3,4,5,6.
3. Same as 2 with STOP_ON_FULL=1 -> o_overflow=1, o_count=4, pops return data 1,2,3,4.
4. HALT_MODE=1, RETIRE with addr=0x00000073 -> remains ARMED, o_halt=0. HALT_MODE=2 with the same stimulus -> HALTED.
5. Assert i_rst during the HALTED readout after 2 of 6 pops -> all outputs return to reset values asynchronously; a following arm plus 1 MEM event gives o_count=1.
6. TRACE_TIMESTAMP_EN defined, arm at cycle 10, RETIRE events at cycles 12 and 15, trigger -> popped timestamps differ by exactly 3.
